led_matrix_scan: RTL and testbench
==================================

# led_matrix_scan

Row-scanning driver for the LED matrix, directly downstream of the clock divider. It samples the divider's `clk_div` output in the system clock domain and advances the row scan on each rising edge of `clk_div`. It holds a double-buffered frame image, written by the pattern logic, and drives the row-enable and column-data pins. Back-buffer writes become visible only at a frame boundary, so the display never tears.

## Interface
- `ROWS`, default 8: matrix rows; one-hot row enable width.
- `COLS`, default 8: matrix columns; column data and write-data width.
- `SHOW_STEPS`, default 4: number of step strobes each row stays lit; must be ≥1.
- `clk` input, 1 bit: system clock; all logic is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `clk_div` input, 1 bit: divider output, same clock domain; only its rising edge is used.
- `wr_en` input, 1 bit: write strobe into the back buffer.
- `wr_row` input, $clog2(ROWS) bits: back-buffer row address; values ≥ROWS are ignored.
- `wr_data` input, COLS bits: row pixel data; bit i is column i, 1 = lit.
- `swap_req` input, 1 bit: one-cycle request to swap the buffers at the next frame boundary.
- `row_en` output, ROWS bits: one-hot active-high row drive, or all-zero.
- `col_data` output, COLS bits: column drive for the enabled row.
- `swap_pending` output, 1 bit: a swap request is waiting for the frame boundary.
- `frame_done` output, 1 bit: one-cycle pulse when the scan wraps from row ROWS-1 to row 0.

## Operation
- Step strobe: `step = clk_div & ~clk_div_q`. `clk_div_q` is a register with reset value 0. If `clk_div` is high when reset is released, a step occurs in the first cycle.
- FSM states:
  - BLANK: `row_en`=0, `col_data`=0.
  - SHOW: `row_en`=onehot(`row_ptr`), `col_data`=front[`row_ptr`].
- Transitions happen only on cycles where `step`=1:
  - BLANK→SHOW: load the outputs; dwell counter `cnt` ← 0.
  - SHOW with `cnt`<SHOW_STEPS-1: `cnt` increments; the FSM stays in SHOW.
  - SHOW with `cnt`=SHOW_STEPS-1: `row_ptr` advances and the FSM goes to BLANK.
- Row wrap: when `row_ptr` goes from ROWS-1 to 0, `frame_done` pulses for one cycle. If `swap_pending` or `swap_req` is set that cycle:
  - the front/back select toggles;
  - `swap_pending` clears.
  - The next SHOW displays the new front buffer.
- `swap_req` outside the wrap cycle sets `swap_pending`. Repeated requests coalesce into one swap.
- Writes always target the back buffer as selected in the write cycle. If a write lands on the swap cycle, it goes to the buffer that becomes front.
- A write does not alter the front buffer, and therefore does not alter `col_data`.

## Timing
- All outputs are registered.
- `row_en`/`col_data` update in the clock cycle after the `clk_div` rising edge is sampled, i.e. latency is 1 clk after `step`.
- `frame_done` is asserted in the same cycle that `row_en` goes to 0 (blank) after the last row.
- Frame period:
  - ROWS×(SHOW_STEPS+1) steps with blanking;
  - ROWS×SHOW_STEPS steps without.
- Reset values:
  - state BLANK, `row_ptr`=0, `cnt`=0;
  - `row_en`=0, `col_data`=0, `frame_done`=0, `swap_pending`=0;
  - front select = buffer 0; both buffers cleared to 0.
- Reset asserted mid-row immediately forces all of the above; no partial row is completed.

## Configuration
- `LED_SCAN_GHOST_BLANK_EN` defined: one BLANK step is inserted between rows, as described above. This is the anti-ghosting behaviour.
- Not defined: no BLANK state after reset-exit.
  - The first step loads row 0 directly into SHOW.
  - At the end of each row's dwell, the FSM goes straight to SHOW of the next row.
  - `row_en` is never all-zero after the first step.
  - `frame_done` is asserted with the load of row 0.

## Structure
- Package `led_matrix_pkg` holds:
  - the scan state enum (BLANK, SHOW);
  - default ROWS/COLS constants;
  - a `onehot` function.
- Sub-module `led_frame_buf` holds two ROWS×COLS bit arrays, the front-select flop, the write port and a combinational read of front[row].

## Test plan
- Reset with `clk_div` toggling every 2 clk → `row_en`=0, `col_data`=0 until the first step; the first SHOW drives `row_en`=8'h01.
- Write row 3 = 8'hA5 without `swap_req` → `col_data` during the row-3 SHOW remains 8'h00.
- Then `swap_req` mid-frame → `swap_pending`=1 until the wrap. `frame_done` pulses once, and the next row-3 SHOW shows 8'hA5.
- `swap_req` in the exact wrap cycle → the swap occurs in that cycle and `swap_pending` is never set.
- Count steps between `frame_done` pulses → 40 with `LED_SCAN_GHOST_BLANK_EN`, 32 without; `row_en` is always one-hot or zero.
- Assert `rst_n` low during the SHOW of row 5 → outputs are 0 immediately. After release, the scan restarts at row 0 with front = buffer 0.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared constants, scan-state encoding and the row one-hot helper for the LED matrix scanner.
package led_matrix_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  localparam int MAX_ROWS = 32;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_e;

  // Callers truncate the result to their own row count.
  function automatic logic [MAX_ROWS-1:0] onehot(input logic [4:0] idx);
    return MAX_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Double-buffered frame image: writes land in the back buffer, reads come from the front buffer.
module led_frame_buf
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap,
  input  logic                    rd_flip,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data
);

  localparam int RW = $clog2(ROWS);

  logic [COLS-1:0] mem0 [ROWS];
  logic [COLS-1:0] mem1 [ROWS];
  logic            front_sel;
  logic            wr_ok;

  generate
    if (ROWS == (2 ** RW)) begin : g_full_range
      assign wr_ok = 1'b1;
    end else begin : g_part_range
      assign wr_ok = (wr_row < RW'(ROWS));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        mem0[r] <= '0;
        mem1[r] <= '0;
      end
    end else begin
      if (swap) front_sel <= ~front_sel;
      if (wr_en && wr_ok) begin
        if (front_sel) mem0[wr_row] <= wr_data;
        else           mem1[wr_row] <= wr_data;
      end
    end
  end

  // rd_flip lets a row load on the swap cycle already see the incoming front buffer.
  assign rd_data = (front_sel ^ rd_flip) ? mem1[rd_row] : mem0[rd_row];

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanning LED matrix driver advanced by rising edges of clk_div.
// LED_SCAN_GHOST_BLANK_EN inserts one blank step between rows (anti-ghosting).
//   state | meaning
//   BLANK | all rows off, waiting for the next step to load a row
//   SHOW  | row_ptr lit with front[row_ptr], dwelling SHOW_STEPS steps
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int SHOW_STEPS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_div,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic [ROWS-1:0]         row_en,
  output logic [COLS-1:0]         col_data,
  output logic                    swap_pending,
  output logic                    frame_done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = (SHOW_STEPS > 1) ? $clog2(SHOW_STEPS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SHOW_STEPS - 1);
  localparam logic [0:0]    BLANK    = SCAN_BLANK;
  localparam logic [0:0]    SHOW     = SCAN_SHOW;

  logic            clk_div_q;
  logic            step;
  logic            dwell_end;
  logic            wrap;
  logic            swap_now;
  logic [0:0]      state;
  logic [RW-1:0]   row_ptr;
  logic [RW-1:0]   row_nxt;
  logic [RW-1:0]   rd_row;
  logic [CW-1:0]   cnt;
  logic [COLS-1:0] rd_data;

  assign step      = clk_div & ~clk_div_q;
  assign dwell_end = step && (state == SHOW) && (cnt == LAST_CNT);
  assign wrap      = dwell_end && (row_ptr == LAST_ROW);
  assign swap_now  = wrap && (swap_pending || swap_req);
  assign row_nxt   = (row_ptr == LAST_ROW) ? '0 : row_ptr + RW'(1);
  // From SHOW the only row ever loaded is the next one; from BLANK it is row_ptr.
  assign rd_row    = (state == SHOW) ? row_nxt : row_ptr;

  led_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_frame_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .swap    (swap_now),
    .rd_flip (swap_now),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_div_q    <= 1'b0;
      state        <= BLANK;
      row_ptr      <= '0;
      cnt          <= '0;
      row_en       <= '0;
      col_data     <= '0;
      frame_done   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      clk_div_q  <= clk_div;
      frame_done <= wrap;
      if (swap_now)      swap_pending <= 1'b0;
      else if (swap_req) swap_pending <= 1'b1;
      if (step) begin
        if (state == BLANK) begin
          state    <= SHOW;
          cnt      <= '0;
          row_en   <= ROWS'(onehot(5'(row_ptr)));
          col_data <= rd_data;
        end else if (cnt != LAST_CNT) begin
          cnt <= cnt + CW'(1);
        end else begin
          row_ptr <= row_nxt;
          cnt     <= '0;
`ifdef LED_SCAN_GHOST_BLANK_EN
          state    <= BLANK;
          row_en   <= '0;
          col_data <= '0;
`else
          row_en   <= ROWS'(onehot(5'(row_nxt)));
          col_data <= rd_data;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan (8x8, 4 show steps); covers both LED_SCAN_GHOST_BLANK_EN builds.
module tb_led_matrix_scan;

  typedef struct {
    int         stp;
    logic [7:0] row_en;
    logic [7:0] col;
    logic       fd;
  } vec_t;

`ifdef LED_SCAN_GHOST_BLANK_EN
  localparam int FP = 40, W1 = 40, R3OFF = 16, R5OFF = 26, R3FIRST = 16;
`else
  localparam int FP = 32, W1 = 33, R3OFF = 12, R5OFF = 20, R3FIRST = 13;
`endif
  localparam int W2 = W1 + FP;
  localparam int W3 = W2 + FP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_div = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic [7:0] row_en;
  logic [7:0] col_data;
  logic       swap_pending;
  logic       frame_done;

  int tests = 0, fails = 0;
  int nstep = 0, last_fd = 0, prev_fd = 0, fd_count = 0, oh_err = 0, fd_err = 0;
  logic prev_fd_lvl = 1'b0;
  logic [7:0] s_row_en, s_col;
  logic s_fd, s_sp;
  vec_t vecs[9];

  led_matrix_scan #(.ROWS(8), .COLS(8), .SHOW_STEPS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_div      (clk_div),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .row_en       (row_en),
    .col_data     (col_data),
    .swap_pending (swap_pending),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, nstep);
    end
  endtask

  task automatic tick(input logic cd, input logic sr);
    @(negedge clk);
    clk_div  = cd;
    swap_req = sr;
    @(posedge clk);
    #1;
    if (!$onehot0(row_en)) oh_err++;
    if (frame_done) begin
      if (prev_fd_lvl) fd_err++;
      fd_count++;
      prev_fd = last_fd;
      last_fd = nstep;
    end
    prev_fd_lvl = frame_done;
  endtask

  // One clk_div period: high 2 clk, low 2 clk; outputs captured right after the step edge.
  task automatic step_once(input logic sr);
    nstep++;
    tick(1'b1, sr);
    s_row_en = row_en;
    s_col    = col_data;
    s_fd     = frame_done;
    s_sp     = swap_pending;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic step_to(input int target);
    while (nstep < target) step_once(1'b0);
  endtask

  task automatic wr(input logic [2:0] row, input logic [7:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_row = row; wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
`ifdef LED_SCAN_GHOST_BLANK_EN
    vecs[0] = '{1, 8'h01, 8'h00, 1'b0};  vecs[1] = '{4, 8'h01, 8'h00, 1'b0};
    vecs[2] = '{5, 8'h00, 8'h00, 1'b0};  vecs[3] = '{6, 8'h02, 8'h00, 1'b0};
    vecs[4] = '{11, 8'h04, 8'h00, 1'b0}; vecs[5] = '{16, 8'h08, 8'h00, 1'b0};
    vecs[6] = '{36, 8'h80, 8'h00, 1'b0}; vecs[7] = '{40, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{41, 8'h01, 8'h00, 1'b0};
`else
    vecs[0] = '{1, 8'h01, 8'h00, 1'b0};  vecs[1] = '{4, 8'h01, 8'h00, 1'b0};
    vecs[2] = '{5, 8'h02, 8'h00, 1'b0};  vecs[3] = '{8, 8'h02, 8'h00, 1'b0};
    vecs[4] = '{9, 8'h04, 8'h00, 1'b0};  vecs[5] = '{13, 8'h08, 8'h00, 1'b0};
    vecs[6] = '{29, 8'h80, 8'h00, 1'b0}; vecs[7] = '{32, 8'h80, 8'h00, 1'b0};
    vecs[8] = '{33, 8'h01, 8'h00, 1'b1};
`endif

    // Reset held while clk_div toggles.
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("rst_row_en", row_en, 8'h00);
    chk("rst_col_data", col_data, 8'h00);
    chk("rst_swap_pending", swap_pending, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-buffer write with no swap must stay invisible for the first frame.
    wr(3'd3, 8'hA5);
    tick(1'b0, 1'b0);
    chk("idle_row_en", row_en, 8'h00);

    for (int i = 0; i < 9; i++) begin
      step_to(vecs[i].stp);
      chk($sformatf("vec%0d_row_en", i), s_row_en, vecs[i].row_en);
      chk($sformatf("vec%0d_col", i), s_col, vecs[i].col);
      chk($sformatf("vec%0d_fd", i), s_fd, vecs[i].fd);
    end

    // Mid-frame swap request waits for the wrap.
    step_to(W1 + 3);
    tick(1'b0, 1'b1);
    chk("swap_pending_set", swap_pending, 1'b1);
    step_to(W2 - 1);
    chk("swap_pending_held", s_sp, 1'b1);
    step_once(1'b0);
    chk("wrap2_fd", s_fd, 1'b1);
    chk("wrap2_sp_clear", s_sp, 1'b0);
    step_to(W2 + R3OFF);
    chk("swap_row3_row_en", s_row_en, 8'h08);
    chk("swap_row3_col", s_col, 8'hA5);

    // A write while row 3 is lit goes to the back buffer only.
    wr(3'd3, 8'h3C);
    step_once(1'b0);
    chk("wr_during_show_col", s_col, 8'hA5);

    // Swap request exactly on the wrap cycle swaps immediately.
    step_to(W3 - 1);
    chk("pre_wrap3_sp", swap_pending, 1'b0);
    step_once(1'b1);
    chk("wrap3_fd", s_fd, 1'b1);
    chk("wrap3_sp", s_sp, 1'b0);
    chk("wrap3_sp_after", swap_pending, 1'b0);
    chk("fd_count", fd_count, 3);
    chk("frame_period", last_fd - prev_fd, FP);
    step_to(W3 + R3OFF);
    chk("wrap_swap_row3_col", s_col, 8'h3C);

    // Reset in the middle of row 5.
    step_to(W3 + R5OFF);
    chk("row5_row_en", s_row_en, 8'h20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_row_en", row_en, 8'h00);
    chk("midrst_col", col_data, 8'h00);
    chk("midrst_sp", swap_pending, 1'b0);
    chk("onehot_violations", oh_err, 0);
    chk("fd_width_violations", fd_err, 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("midrst_hold_row_en", row_en, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    nstep = 0;
    step_once(1'b0);
    chk("restart_row_en", s_row_en, 8'h01);
    chk("restart_fd", s_fd, 1'b0);
    step_to(R3FIRST);
    chk("restart_row3_row_en", s_row_en, 8'h08);
    chk("restart_row3_col", s_col, 8'h00);
    chk("restart_sp", s_sp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
